// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants and FSM state type for the nibble-serial adder
package adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_adder.sv
// rtl/nibble_adder.sv - 4-bit ripple-carry adder slice
module nibble_adder
    import adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - sequences a WIDTH-bit add/subtract through one nibble adder, LSB first
module nibble_serial_add_ctrl
    import adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                      cin,
    input  logic                      sub,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
    output logic                      cout,
    output logic                      busy
);

    localparam int WIDTH = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   sum_q;
    logic               carry_q;

    logic [NIBBLE_W-1:0] nib_a;
    logic [NIBBLE_W-1:0] nib_b;
    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_cout;
    logic                last_nibble;

    assign last_nibble = (idx_q == IDX_W'(NIBBLES - 1));
    assign nib_a       = a_q[idx_q * NIBBLE_W +: NIBBLE_W];
    assign nib_b       = b_q[idx_q * NIBBLE_W +: NIBBLE_W];

    nibble_adder u_nibble_adder (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_nibble) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // B is inverted at acceptance so subtract is just A + ~B with carry-in forced to 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b ^ {WIDTH{sub}};
                        carry_q <= sub ? 1'b1 : cin;
                        idx_q   <= '0;
                        sum_q   <= '0;
                    end
                end
                RUN: begin
                    sum_q[idx_q * NIBBLE_W +: NIBBLE_W] <= nib_sum;
                    carry_q                             <= nib_cout;
                    idx_q                               <= idx_q + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = (state_q == DONE) & carry_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - directed self-checking bench for nibble_serial_add_ctrl
module tb_nibble_serial_add_ctrl;

    localparam int NIBBLES = 4;
    localparam int WIDTH   = 4 * NIBBLES;
    localparam int LAT     = NIBBLES + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string name, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                          input logic vcin, input logic vsub, input logic [WIDTH-1:0] exp_sum,
                          input logic exp_cout, input bit zero_ops);
        int  cyc;
        bit  rdy_seen;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s in_ready_before_accept: got %b want 1", name, in_ready);
        end
        a = va; b = vb; cin = vcin; sub = vsub; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        if (zero_ops) begin
            a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        end
        cyc      = 1;
        rdy_seen = 1'b0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            if (in_ready !== 1'b0) rdy_seen = 1'b1;
            tick();
            cyc++;
        end
        n_cmp++;
        if (cyc != LAT) begin
            n_bad++;
            $display("FAIL %s latency: got %0d cycles want %0d", name, cyc, LAT);
        end
        n_cmp++;
        if (rdy_seen || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL %s in_ready_while_busy: got high want 0", name);
        end
        n_cmp++;
        if (sum !== exp_sum) begin
            n_bad++;
            $display("FAIL %s sum: got %h want %h", name, sum, exp_sum);
        end
        n_cmp++;
        if (cout !== exp_cout) begin
            n_bad++;
            $display("FAIL %s cout: got %b want %b", name, cout, exp_cout);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s after_handshake: got rdy=%b ov=%b busy=%b want 1 0 0",
                     name, in_ready, out_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
        tick();
        tick();
        rst = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: got rdy=%b ov=%b busy=%b sum=%h cout=%b want 1 0 0 0000 0",
                     in_ready, out_valid, busy, sum, cout);
        end
    endtask

    task automatic test_basic();
        run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    endtask

    task automatic test_carry();
        run_op("carry_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("carry_in",     16'h000F, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0);
    endtask

    task automatic test_subtract();
        run_op("sub_no_borrow", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
        run_op("sub_borrow",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        a = 16'hABCD; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 30 && out_valid !== 1'b1; i++) tick();
        a = 16'h0F0F; b = 16'h0F0F; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 16'hBCDE || cout !== 1'b0) begin
                n_bad++;
                $display("FAIL backpressure_hold%0d: got ov=%b rdy=%b sum=%h cout=%b want 1 0 bcde 0",
                         i, out_valid, in_ready, sum, cout);
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL backpressure_release: got rdy=%b ov=%b want 1 0", in_ready, out_valid);
        end
        run_op("after_backpressure", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    endtask

    task automatic test_operand_change();
        run_op("operand_change", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_run();
        a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1; in_valid = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_run: got rdy=%b ov=%b busy=%b sum=%h cout=%b want 1 0 0 0000 0",
                     in_ready, out_valid, busy, sum, cout);
        end
        run_op("post_reset_add", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_op("b2b_first",  16'h0F0F, 16'h0101, 1'b1, 1'b0, 16'h1011, 1'b0, 1'b0);
        run_op("b2b_second", 16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_subtract();
        test_backpressure();
        test_operand_change();
        test_reset_mid_run();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nibble_serial_add_ctrl.md
# nibble_serial_add_ctrl

Sequencing controller that performs a WIDTH-bit add or subtract by time-multiplexing one 4-bit ripple adder, one nibble per cycle, LSB first. It sits between a valid/ready request source and a valid/ready result sink. It is the area-saving alternative to a full-width adder wherever throughput of one operation per NIBBLES+2 cycles is acceptable.

## Interface
Parameters:
- NIBBLES, 4: number of 4-bit slices. WIDTH = 4*NIBBLES. Legal range is 1..16.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  controller can accept a request.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; used only when sub=0.
- sub  in  1  0 = A+B+cin; 1 = A−B (A + ~B + 1, cin ignored).
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  final carry. In sub mode, 1 = no borrow.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid: latch a, b^{WIDTH{sub}}, and carry := sub ? 1 : cin. Clear idx and the sum register. Go to RUN.
- **RUN**
  - Each cycle, feed nibble idx of A, nibble idx of B', and carry to the adder.
  - Write the adder's 4-bit sum into sum[4*idx+:4]. Set carry := adder cout. Increment idx.
  - When idx==NIBBLES−1 on this cycle, go to DONE.
- **DONE**
  - out_valid=1. cout = carry.
  - sum and cout stay stable until out_ready.
  - On out_ready, go to IDLE.
- No request overlap:
  - in_ready=0 in RUN and DONE.
  - in_valid and operand changes there are ignored.
  - The operands used are those latched at acceptance.
- Width rule: the result is modulo 2^WIDTH. cout is the carry out of nibble NIBBLES−1.
- Carry chain between nibbles is the registered carry. The internal adder's carry-in must be honoured on every nibble, including nibble 0.
- **Reset (any state, including mid-RUN or DONE)**
  - Next cycle: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, idx=0, carry=0.
  - The in-flight operation is discarded.
  - A request presented in the same cycle as rst is not accepted.

## Timing
- Accept edge E0: IDLE with in_valid=1.
- Edges E1..E_NIBBLES process nibbles 0..NIBBLES−1.
- out_valid rises in the cycle after E_NIBBLES, i.e. NIBBLES+1 cycles after the accept cycle. This is 5 cycles for NIBBLES=4.
- Result handshake on the edge where out_valid & out_ready. in_ready is high in the following cycle.
- Minimum initiation interval is NIBBLES+2 cycles, with out_ready held high.
- Outputs are registered or decoded directly from the state register. There is no combinational path from in_valid or out_ready to any output.
- NIBBLES=1: RUN lasts exactly one cycle.

## Structure
- Shared package `adder_pkg`:
  - constant NIBBLE_W=4.
  - typedef enum state_t {IDLE, RUN, DONE}.
- One sub-module `nibble_adder`: 4-bit ripple-carry adder (a[3:0], b[3:0], cin, sum[3:0], cout), with cin connected through to bit 0.
- Controller: FSM, operand/sum registers, $clog2(NIBBLES)-bit idx counter, carry flop.

## Test plan
All scenarios use NIBBLES=4.
1. a=0x1234, b=0x4321, cin=0, sub=0.
   - Required: sum=0x5555, cout=0.
   - out_valid first high exactly 5 cycles after accept.
   - in_ready=0 throughout.
2. Carry propagation and carry-in:
   - a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1. Carry ripples through all four nibbles.
   - a=0x000F, b=0x0000, cin=1 → sum=0x0010, cout=0.
3. Subtract:
   - sub=1, a=0x0007, b=0x0005, cin=1 → sum=0x0002, cout=1. cin is ignored.
   - sub=1, a=0x0005, b=0x0007 → sum=0xFFFE, cout=0.
4. Backpressure: out_ready held 0 for 3 cycles in DONE.
   - sum and cout remain constant.
   - A new in_valid is ignored.
   - After the out_ready pulse, in_ready=1 the next cycle. The next request then completes normally.
5. Operand change mid-RUN:
   - a and b toggled to 0 after acceptance of 0x1111+0x2222.
   - Required: result 0x3333.
6. rst asserted in the second RUN cycle.
   - Next cycle: IDLE, out_valid=0, in_ready=1, sum=0, cout=0.
   - A following 0x0001+0x0001 yields 0x0002 with normal latency.
